// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single write port of the 32x32 register file and shares it
//   between two writers:
//     - the in-order pipeline writeback stage, which normally has priority;
//     - the long-latency unit (load/mul/div results), which is forced through
//       after it has been refused STARVE_MAX cycles in a row.
//   Arbitration is zero-cycle: grants, the write port and handshakes are all
//   combinational from the current inputs and the registered state.
//
//   The block also keeps a busy-bit scoreboard of registers that have an
//   outstanding long-latency result. It raises a RAW/WAW hazard to the issue
//   stage when any of that stage's registers is marked busy.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   pipe_wen/rd/data          pipeline writeback request
//   pipe_stall                pipeline writeback must hold (not written)
//   ll_valid/rd/data          long-latency result request
//   ll_ready                  long-latency result accepted this cycle
//   ll_issue/ll_issue_rd      long-latency op issued; marks its destination busy
//   rs1_addr/rs2_addr/issue_rd  issue-stage registers checked against the
//                               scoreboard
//   hazard                    issue stage must stall
//   RegWEn/rd_addr/rd_data    register file write port
//   busy_vec                  scoreboard state; bit 0 is always 0
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            ll_valid,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    output logic            ll_ready,
    input  logic            ll_issue,
    input  logic [4:0]      ll_issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      issue_rd,
    output logic            hazard,
    output logic            RegWEn,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [31:0]     busy_vec
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic [31:1] busy_reg;
    logic [31:1] set_vec;
    logic [31:1] clr_vec;
    logic [31:0] busy_full;

    logic pipe_req;
    logic ll_req;
    logic ll_zero;
    logic forced;
    logic pipe_grant;
    logic ll_grant;

    // x0 is never written, so requests to it are dropped.
    // A long-latency result for x0 is acknowledged at once without a write.
    assign pipe_req = pipe_wen & (pipe_rd != 5'd0);
    assign ll_req   = ll_valid & (ll_rd != 5'd0);
    assign ll_zero  = ll_valid & (ll_rd == 5'd0);
    assign forced   = (starve_cnt_reg == STARVE_LIMIT);

    // The pipeline wins unless the long-latency unit has starved long enough.
    // Once forced, the pipeline only loses when there really is a competing
    // long-latency request.
    assign ll_grant   = ll_req & (forced | ~pipe_req);
    assign pipe_grant = pipe_req & ~ll_grant;

    // The whole handshake and write interface is held quiet while reset is
    // asserted, independent of the clock.
    always_comb begin
        RegWEn     = 1'b0;
        rd_addr    = 5'd0;
        rd_data    = '0;
        ll_ready   = 1'b0;
        pipe_stall = 1'b0;
        if (!rst) begin
            ll_ready   = ll_grant | ll_zero;
            pipe_stall = pipe_req & ll_grant;
            RegWEn     = pipe_grant | ll_grant;
            if (pipe_grant) begin
                rd_addr = pipe_rd;
                rd_data = pipe_data;
            end else if (ll_grant) begin
                rd_addr = ll_rd;
                rd_data = ll_data;
            end
        end
    end

    // Count consecutive refusals. Any cycle without a refused request
    // (accepted, or no request at all) restarts the count.
    always_comb begin
        starve_cnt_next = 4'd0;
        if (ll_req && !ll_grant) begin
            if (starve_cnt_reg != STARVE_LIMIT)
                starve_cnt_next = starve_cnt_reg + 4'd1;
            else
                starve_cnt_next = starve_cnt_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt_reg <= 4'd0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end

    // One busy bit per architectural register except x0.
    // A new issue to a register beats the clear of that register, so a
    // back-to-back reissue is not lost.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            assign set_vec[gi] = ll_issue & (ll_issue_rd == 5'(gi));
            assign clr_vec[gi] = ll_grant & (ll_rd == 5'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    busy_reg[gi] <= 1'b0;
                else
                    busy_reg[gi] <= set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    assign busy_full = {busy_reg, 1'b0};
    assign busy_vec  = rst ? 32'd0 : busy_full;

    // There is no bypass from a clear in this cycle. The result lands in the
    // register file at the coming edge, so the first clean read is next cycle.
    assign hazard = ~rst & (busy_full[rs1_addr] | busy_full[rs2_addr] |
                            busy_full[issue_rd]);

endmodule
